// File: rtl/pl_mem_pkg.sv
// Shared types for the byte-serial data-memory initiator.
// Holds the RV32I load/store width codes, FSM states and size decode.
package pl_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Byte count of an access; code 11 is treated as a full word.
   function automatic logic [2:0] size_bytes(input logic [2:0] f3);
      logic [2:0] n;
      case (f3[1:0])
         2'b00:   n = 3'd1;
         2'b01:   n = 3'd2;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/pl_mem_access_unit_extend.sv
// Load-result extension: sign/zero-extends byte and half loads.
// Purely combinational so the forwarding path can reuse it.
module pl_load_extend
   import pl_mem_pkg::*;
#(
   parameter int WD = 32
) (
   input  logic [WD-1:0] i_raw,
   input  logic [2:0]    i_func3,
   output logic [WD-1:0] o_ext
);

   logic w_unsigned;

   assign w_unsigned = i_func3[2];

   // Pick extension by access size; words and code 11 pass through.
   always_comb begin
      o_ext = i_raw;
      case (i_func3[1:0])
         2'b00: begin
            if (w_unsigned)
               o_ext = {{(WD-8){1'b0}}, i_raw[7:0]};
            else
               o_ext = {{(WD-8){i_raw[7]}}, i_raw[7:0]};
         end
         2'b01: begin
            if (w_unsigned)
               o_ext = {{(WD-16){1'b0}}, i_raw[15:0]};
            else
               o_ext = {{(WD-16){i_raw[15]}}, i_raw[15:0]};
         end
         default: o_ext = i_raw;
      endcase
   end

endmodule

// File: rtl/pl_mem_access_unit.sv
// MEM-stage initiator: runs one load/store as byte-serial accesses.
// Little-endian; busy stalls the pipe until the response pulse.
module pl_mem_access_unit
   import pl_mem_pkg::*;
#(
   parameter int WA = 32,
   parameter int WB = 8,
   parameter int WD = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   input  logic          req_write,
   input  logic [2:0]    func3,
   input  logic [WA-1:0] req_addr,
   input  logic [WD-1:0] req_wdata,
   output logic          req_ready,
   output logic          busy,
   output logic          resp_valid,
   output logic [WD-1:0] resp_rdata,
   output logic [WA-1:0] mem_addr,
   output logic          mem_we,
   output logic [WB-1:0] mem_wdata,
   input  logic [WB-1:0] mem_rdata
);

   state_t        r_state;
   state_t        w_next;
   logic [1:0]    r_k;
   logic [WA-1:0] r_addr;
   logic [WD-1:0] r_wdata;
   logic [WD-1:0] r_asm;
   logic [2:0]    r_func3;
   logic          r_write;

   logic [2:0]    w_n;
   logic          w_last;
   logic          w_accept;
   logic          w_skip;
   logic [WD-1:0] w_ext;

   assign w_n      = size_bytes(r_func3);
   assign w_last   = ({1'b0, r_k} == (w_n - 3'd1));
   assign w_accept = req_valid && (r_state == IDLE);
   // A store with code 11 has no defined width: complete without writing.
   assign w_skip   = req_write && (func3[1:0] == 2'b11);

   pl_load_extend #(
      .WD(WD)
   ) u_ext (
      .i_raw  (r_asm),
      .i_func3(r_func3),
      .o_ext  (w_ext)
   );

   // State register; reset overrides any request in the same cycle.
   always_ff @(posedge clk) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   // Next state and all handshake/memory outputs, decoded from state.
   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      busy       = 1'b1;
      resp_valid = 1'b0;
      resp_rdata = '0;
      mem_addr   = '0;
      mem_we     = 1'b0;
      mem_wdata  = '0;
      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid)
               w_next = w_skip ? DONE : ACCESS;
         end
         ACCESS: begin
            mem_addr = r_addr + WA'(r_k);
            if (r_write) begin
               mem_we    = 1'b1;
               mem_wdata = r_wdata[r_k*WB +: WB];
            end
            if (w_last)
               w_next = DONE;
         end
         DONE: begin
            resp_valid = 1'b1;
            resp_rdata = r_write ? '0 : w_ext;
            w_next     = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Latch the request on accept; step the byte counter and assemble loads.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_k     <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_asm   <= '0;
         r_func3 <= '0;
         r_write <= 1'b0;
      end else if (w_accept) begin
         r_k     <= '0;
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
         r_asm   <= '0;
         r_func3 <= func3;
         r_write <= req_write;
      end else if (r_state == ACCESS) begin
         r_k <= r_k + 2'd1;
         if (!r_write)
            r_asm[r_k*WB +: WB] <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_pl_mem_access_unit.sv
// Bench for pl_mem_access_unit: vector table, random ops vs a
// byte-array model, plus reset and held-request sequences.
module tb_pl_mem_access_unit;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_write;
   logic [2:0]  func3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        busy;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   pl_mem_access_unit dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_write (req_write),
      .func3     (func3),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .busy      (busy),
      .resp_valid(resp_valid),
      .resp_rdata(resp_rdata),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] mem  [logic [31:0]];
   logic [7:0] xmem [logic [31:0]];
   int mem_gen = 0;
   int checks = 0;
   int failures = 0;
   int wes_cnt = 0;
   logic [31:0] alog [$];

   typedef struct {
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      int          exp_lat;
      int          exp_wes;
   } vec_t;
   vec_t tbl [$];

   function automatic logic [7:0] rdm(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 8'h00;
   endfunction

   function automatic logic [7:0] rdx(input logic [31:0] a);
      if (xmem.exists(a)) return xmem[a];
      return 8'h00;
   endfunction

   always @(mem_addr or mem_gen) mem_rdata = rdm(mem_addr);

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic poke(input logic [31:0] a, input logic [7:0] d);
      mem[a] = d;
      xmem[a] = d;
      mem_gen++;
   endtask

   // Reference: n bytes little-endian, then sign/zero rule by arithmetic.
   task automatic model(input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat,
                        output int wes);
      int n;
      logic [31:0] v;
      n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      rd = 32'h0;
      wes = 0;
      lat = n + 1;
      if (wr) begin
         if (f3[1:0] == 2'b11) begin
            lat = 1;
         end else begin
            for (int k = 0; k < n; k++)
               xmem[a + 32'(k)] = 8'(wd >> (8 * k));
            wes = n;
         end
      end else begin
         v = 32'h0;
         for (int k = 0; k < n; k++)
            v = v + (32'(rdx(a + 32'(k))) << (8 * k));
         if (!f3[2] && n == 1 && v >= 32'h80) v = v - 32'h100;
         if (!f3[2] && n == 2 && v >= 32'h8000) v = v - 32'h10000;
         rd = v;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (mem_we) begin
         mem[mem_addr] = mem_wdata;
         mem_gen++;
         wes_cnt++;
      end
      if (busy && !resp_valid) alog.push_back(mem_addr);
   endtask

   task automatic issue(input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
      int g;
      g = 0;
      @(negedge clk);
      while (!req_ready && g < 40) begin
         @(negedge clk);
         g++;
      end
      chk("issue_ready", 32'(req_ready), 32'h1);
      req_valid = 1'b1;
      req_write = wr;
      func3 = f3;
      req_addr = a;
      req_wdata = wd;
      alog.delete();
      wes_cnt = 0;
   endtask

   task automatic run(input int drop_at, input int inj_at,
                      output logic [31:0] rd, output int lat,
                      output logic ball);
      lat = -1;
      rd = 32'h0;
      ball = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         step();
         if (c == drop_at) req_valid = 1'b0;
         if (c == inj_at) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            func3 = 3'b000;
            req_addr = 32'h20;
            req_wdata = 32'h5555_5555;
         end
         if (!busy) ball = 1'b0;
         if (resp_valid) begin
            lat = c;
            rd = resp_rdata;
            chk("done_addr", mem_addr, 32'h0);
            chk("done_we", 32'(mem_we), 32'h0);
            chk("done_ready", 32'(req_ready), 32'h0);
            break;
         end
      end
      if (lat < 0) begin
         checks++;
         failures++;
         $display("FAIL resp_timeout actual=none required=resp_valid");
      end
   endtask

   task automatic do_op(input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat,
                        output int wes);
      logic ball;
      issue(wr, f3, a, wd);
      run(1, 0, rd, lat, ball);
      wes = wes_cnt;
      chk("busy_hold", 32'(ball), 32'h1);
      for (int i = 0; i < alog.size(); i++)
         chk("addr_seq", alog[i], a + 32'(i));
      step();
      chk("rv_drop", 32'(resp_valid), 32'h0);
      chk("rd_drop", resp_rdata, 32'h0);
      chk("idle_ready", 32'(req_ready), 32'h1);
   endtask

   task automatic addv(input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] erd, input int elat,
                       input int ewes);
      vec_t v;
      v.wr = wr; v.f3 = f3; v.addr = a; v.wd = wd;
      v.exp_rd = erd; v.exp_lat = elat; v.exp_wes = ewes;
      tbl.push_back(v);
   endtask

   initial begin
      logic [31:0] rd, mrd;
      int lat, wes, mlat, mwes;
      logic ball;
      logic wr;
      logic [2:0] f3;
      logic [31:0] a, wd;
      int seen;

      rst = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      func3 = 3'b000;
      req_addr = 32'h0;
      req_wdata = 32'h0;

      poke(32'h10000, 8'h78); poke(32'h10001, 8'h56);
      poke(32'h10002, 8'h34); poke(32'h10003, 8'h12);
      poke(32'h1F, 8'h00); poke(32'h20, 8'h80); poke(32'h21, 8'h7F);
      poke(32'hFFFFFFFF, 8'hAA); poke(32'h0, 8'hBB);
      poke(32'h1, 8'hCC); poke(32'h2, 8'hDD);
      poke(32'h10, 8'h00); poke(32'h11, 8'h00); poke(32'h12, 8'h99);
      poke(32'h40, 8'h11); poke(32'h41, 8'h22);
      poke(32'h42, 8'h33); poke(32'h43, 8'h44);

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("rst_ready", 32'(req_ready), 32'h1);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_rv", 32'(resp_valid), 32'h0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_we", 32'(mem_we), 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wdata", 32'(mem_wdata), 32'h0);

      // Reset and request together: reset wins.
      @(negedge clk);
      rst = 1'b1;
      req_valid = 1'b1;
      req_write = 1'b0;
      func3 = 3'b010;
      req_addr = 32'h10000;
      step();
      chk("rst_wins_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      req_valid = 1'b0;

      addv(0, 3'b010, 32'h10000, 0, 32'h12345678, 5, 0);
      addv(0, 3'b000, 32'h20, 0, 32'hFFFFFF80, 2, 0);
      addv(0, 3'b100, 32'h20, 0, 32'h00000080, 2, 0);
      addv(0, 3'b001, 32'h20, 0, 32'h00007F80, 3, 0);
      addv(0, 3'b101, 32'h20, 0, 32'h00007F80, 3, 0);
      addv(0, 3'b001, 32'h1F, 0, 32'hFFFF8000, 3, 0);
      addv(0, 3'b001, 32'h10001, 0, 32'h00003456, 3, 0);
      addv(0, 3'b000, 32'h10003, 0, 32'h00000012, 2, 0);
      addv(0, 3'b010, 32'hFFFFFFFF, 0, 32'hDDCCBBAA, 5, 0);
      addv(1, 3'b001, 32'h10, 32'hABCD1234, 32'h0, 3, 2);
      addv(1, 3'b011, 32'h30, 32'h11223344, 32'h0, 1, 0);
      addv(0, 3'b011, 32'h10000, 0, 32'h12345678, 5, 0);
      addv(1, 3'b000, 32'h50, 32'h777777A5, 32'h0, 2, 1);
      addv(0, 3'b000, 32'h50, 0, 32'hFFFFFFA5, 2, 0);
      addv(0, 3'b101, 32'h10, 0, 32'h00001234, 3, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         model(tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd,
               mrd, mlat, mwes);
         do_op(tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd,
               rd, lat, wes);
         chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
         chk($sformatf("vec%0d_wes", i), 32'(wes), 32'(tbl[i].exp_wes));
         chk($sformatf("vec%0d_nacc", i), 32'(alog.size()),
             32'(tbl[i].exp_lat - 1));
      end
      chk("sh_b0", 32'(rdm(32'h10)), 32'h34);
      chk("sh_b1", 32'(rdm(32'h11)), 32'h12);
      chk("sh_untouched", 32'(rdm(32'h12)), 32'h99);
      chk("sx_untouched", 32'(rdm(32'h30)), 32'h00);

      // Wrap-around address walk.
      do_op(0, 3'b010, 32'hFFFFFFFF, 0, rd, lat, wes);
      chk("wrap_n", 32'(alog.size()), 32'd4);
      if (alog.size() == 4) begin
         chk("wrap_a0", alog[0], 32'hFFFFFFFF);
         chk("wrap_a1", alog[1], 32'h0);
         chk("wrap_a2", alog[2], 32'h1);
         chk("wrap_a3", alog[3], 32'h2);
      end

      // Held second request while busy is ignored until IDLE.
      issue(0, 3'b010, 32'h10000, 0);
      run(1, 3, rd, lat, ball);
      chk("hold_first_rd", rd, 32'h12345678);
      chk("hold_first_lat", 32'(lat), 32'd5);
      chk("hold_first_n", 32'(alog.size()), 32'd4);
      if (alog.size() == 4)
         chk("hold_first_a3", alog[3], 32'h10003);
      alog.delete();
      run(2, 0, rd, lat, ball);
      chk("hold_second_lat", 32'(lat), 32'd3);
      chk("hold_second_rd", rd, 32'hFFFFFF80);
      chk("hold_second_n", 32'(alog.size()), 32'd1);
      if (alog.size() == 1)
         chk("hold_second_a", alog[0], 32'h20);
      req_valid = 1'b0;
      step();

      // Reset in the middle of a word store.
      issue(1, 3'b010, 32'h40, 32'hDEADBEEF);
      step();
      req_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      chk("mid_rst_busy", 32'(busy), 32'h0);
      chk("mid_rst_we", 32'(mem_we), 32'h0);
      chk("mid_rst_rv", 32'(resp_valid), 32'h0);
      chk("mid_rst_ready", 32'(req_ready), 32'h1);
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (resp_valid || mem_we) seen++;
      end
      chk("mid_rst_quiet", 32'(seen), 32'd0);
      chk("mid_rst_40", 32'(rdm(32'h40)), 32'hEF);
      chk("mid_rst_41", 32'(rdm(32'h41)), 32'hBE);
      chk("mid_rst_42", 32'(rdm(32'h42)), 32'h33);
      chk("mid_rst_43", 32'(rdm(32'h43)), 32'h44);
      xmem[32'h40] = 8'hEF;
      xmem[32'h41] = 8'hBE;

      // Random traffic against the byte-array model.
      for (int i = 0; i < 60; i++) begin
         wr = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0)
            a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
         else
            a = 32'h1000 + 32'($urandom_range(0, 63));
         wd = $urandom;
         model(wr, f3, a, wd, mrd, mlat, mwes);
         do_op(wr, f3, a, wd, rd, lat, wes);
         chk($sformatf("rnd%0d_rdata", i), rd, mrd);
         chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(mlat));
         chk($sformatf("rnd%0d_wes", i), 32'(wes), 32'(mwes));
         if (wr) begin
            for (int k = 0; k < 4; k++)
               chk($sformatf("rnd%0d_mem%0d", i, k),
                   32'(rdm(a + 32'(k))), 32'(rdx(a + 32'(k))));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
